seq_shift_add_multiplier: RTL
=============================

Name: seq_shift_add_multiplier

Overview:
- Parametrised sequential successor to the 2-bit combinational `multiplier` block, generalised to WIDTH-bit operands.
- Iterative radix-2 shift-add multiplier with optional signed mode.
- valid/ready handshake on input and output; one multiplication in flight.
- Sits between the RL-driven design-space-exploration stimulus generator and result checker, as the area-minimal point of the multiplier design space.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands A, B and signed_mode are valid this cycle.
- in_ready  output  1  block can accept operands; high only in IDLE.
- A  input  WIDTH  multiplicand.
- B  input  WIDTH  multiplier.
- signed_mode  input  1  1: A and B are two's complement; 0: unsigned. Sampled at acceptance.
- out_valid  output  1  P holds a completed product.
- out_ready  input  1  consumer accepts P this cycle.
- P  output  2*WIDTH  product; held stable while out_valid=1.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, P=0, counter=0.
  - Internal mcand/mplier/acc cleared.
  - Overrides any operation in progress; the in-flight result is discarded, never emitted.
- Acceptance: at an edge with in_valid=1 and in_ready=1.
  - Latch operands. In signed mode, latch magnitudes |A| and |B|, and neg = A[MSB] XOR B[MSB].
  - mcand = zero-extended magnitude of A (2*WIDTH bits); mplier = magnitude of B; acc = 0; counter = WIDTH.
  - state -> CALC.
- CALC, each edge:
  - If mplier[0]=1, acc += mcand (mod 2^(2*WIDTH)).
  - mcand <<= 1; mplier >>= 1; counter -= 1.
  - When counter reaches 0 on this edge: P = neg ? -(acc_next) : acc_next, computed two's complement in 2*WIDTH bits; out_valid=1; state -> DONE.
- Latency: out_valid rises exactly WIDTH edges after the acceptance edge (unless the optional feature is enabled).
- DONE:
  - P and out_valid are held until an edge with out_ready=1.
  - On that edge: out_valid=0, state -> IDLE, in_ready=1 from the next cycle.
  - No same-cycle turnaround: a new acceptance is only possible in the cycle after the output handshake.
- In CALC and DONE, in_ready=0. in_valid is ignored and its operands are not queued.
- Width rules:
  - Signed magnitude of the most-negative value (-2^(WIDTH-1)) is 2^(WIDTH-1), held in WIDTH bits as unsigned.
  - Product magnitude is at most 2^(2*WIDTH-2), so no overflow in 2*WIDTH bits.
  - Unsigned max: (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- Zero operands need no special case (see optional feature).
- signed_mode changes after acceptance have no effect on the in-flight operation.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- When defined:
  - In CALC, if the shifted mplier_next == 0, that edge finalises P, sets out_valid=1 and goes to DONE regardless of counter.
  - Latency becomes max(1, index of highest set bit of |B| + 1) edges. Example: B=0 or B=1 gives latency 1.
  - The sign fix and all other rules are unchanged.
- When undefined: fixed WIDTH-edge latency for all operands.

Test Plan:
- WIDTH=2, unsigned, all 16 A/B pairs with out_ready=1 -> P=A*B each time (e.g., A=3, B=3 -> P=9); out_valid exactly 2 edges after acceptance.
- WIDTH=8, unsigned, A=255, B=255 -> P=65025 (0xFE01). A=2, B=3 -> P=6. Latency 8 edges without MULT_EARLY_TERM_EN.
- WIDTH=8, signed: A=-1 (0xFF), B=-1 -> P=1. A=-128 (0x80), B=127 -> P=0xC080 (-16256). A=-128, B=-128 -> P=0x4000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> P stable, in_ready=0, and a new in_valid pulse is ignored. Raise out_ready -> in_ready=1 next cycle.
- Reset mid-operation: assert rst at CALC iteration 3 of A=7, B=9 -> next cycle out_valid=0, P=0, in_ready=1. A new A=4, B=5 -> P=20 with no trace of the aborted op.
- With MULT_EARLY_TERM_EN, WIDTH=8: A=200, B=1 -> P=200 after 1 edge. A=3, B=0 -> P=0 after 1 edge. A=5, B=0x80 -> P=640 after 8 edges.

Source files
------------

// File: rtl/seq_shift_add_multiplier.sv
// ----------------------------------------------------------------------------
// seq_shift_add_multiplier
//
// Iterative radix-2 shift-add multiplier with an optional two's complement
// mode. One multiplication is in flight at a time. Operands enter on a
// valid/ready handshake and the product leaves on a second valid/ready
// handshake.
//
// Signed operation works on magnitudes. The sign of the product is recorded
// at acceptance and applied to the final accumulator.
//
// Build option:
//   MULT_EARLY_TERM_EN - when defined, CALC finishes as soon as the shifted
//                        multiplier becomes zero. Latency is then
//                        max(1, msb index of |B| + 1) edges instead of a
//                        fixed WIDTH edges.
//
// Parameters:
//   WIDTH        operand width (2..32); the product is 2*WIDTH bits
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   in_valid     A, B and signed_mode are valid this cycle
//   in_ready     operands can be accepted (IDLE only)
//   A            multiplicand
//   B            multiplier
//   signed_mode  1: operands are two's complement, 0: unsigned
//   out_valid    P holds a completed product
//   out_ready    consumer takes P this cycle
//   P            product, stable while out_valid is high
//   busy         operation in CALC or waiting in DONE
// ----------------------------------------------------------------------------
module seq_shift_add_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   P,
   output logic                 busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int PW    = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Magnitude of an operand. The most-negative value maps onto itself as a
   // bit pattern, which read unsigned is exactly 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic is_signed);
      logic signed [WIDTH-1:0] sv;
      sv = v;
      if (is_signed && sv[WIDTH-1]) begin
         magnitude = -sv;
      end else begin
         magnitude = v;
      end
   endfunction

   // Two's complement negation in the full product width.
   function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag,
                                                input logic neg);
      if (neg) begin
         apply_sign = ~mag + PW'(1);
      end else begin
         apply_sign = mag;
      end
   endfunction

   state_t             state_q, state_d;
   logic [PW-1:0]      mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [PW-1:0]      acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic [PW-1:0]      p_q, p_d;

   logic [PW-1:0]      acc_step;
   logic [WIDTH-1:0]   mplier_shift;
   logic [CNT_W-1:0]   cnt_dec;
   logic               finish;

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      p_d      = p_q;

      // One radix-2 step: conditional add, then shift both operands.
      acc_step     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mplier_shift = mplier_q >> 1;
      cnt_dec      = cnt_q - CNT_W'(1);
`ifdef MULT_EARLY_TERM_EN
      // Once no multiplier bits are left, later steps cannot change acc.
      finish = (cnt_dec == '0) || (mplier_shift == '0);
`else
      finish = (cnt_dec == '0);
`endif

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               mcand_d  = {{WIDTH{1'b0}}, magnitude(A, signed_mode)};
               mplier_d = magnitude(B, signed_mode);
               acc_d    = '0;
               cnt_d    = CNT_W'(WIDTH);
               neg_d    = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
               state_d  = CALC;
            end
         end
         CALC: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_shift;
            cnt_d    = cnt_dec;
            if (finish) begin
               p_d     = apply_sign(acc_step, neg_q);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A reset also clears the datapath, so an aborted product never shows on P.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         p_q      <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         p_q      <= p_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign P         = p_q;

endmodule
